// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL DRP reconfiguration controller:
// state codes, error codes, DRP widths and the read-modify-write merge.
package pll_ctrl_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;

    typedef logic [2:0] state_t;

    // Sequencer states. ST_DRP_BUSY is the top-level view of the whole
    // RD_REQ..WR_WAIT span, which the DRP port sub-module walks through.
    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_RD_REQ     = 3'd1;
    localparam state_t ST_RD_WAIT    = 3'd2;
    localparam state_t ST_WR_REQ     = 3'd3;
    localparam state_t ST_WR_WAIT    = 3'd4;
    localparam state_t ST_RST_ASSERT = 3'd5;
    localparam state_t ST_LOCK_WAIT  = 3'd6;
    localparam state_t ST_DRP_BUSY   = 3'd7;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RD_TO   = 2'd1;
    localparam logic [1:0] ERR_WR_TO   = 2'd2;
    localparam logic [1:0] ERR_LOCK_TO = 2'd3;

    // Keep current bits where mask is 0, take new bits where mask is 1.
    function automatic logic [DATA_W-1:0] merge_bits(
        input logic [DATA_W-1:0] cur_bits,
        input logic [DATA_W-1:0] new_bits,
        input logic [DATA_W-1:0] mask_bits
    );
        return (cur_bits & ~mask_bits) | (new_bits & mask_bits);
    endfunction

endpackage

// File: rtl/drp_rmw_port.sv
// One masked read-modify-write on the PLL DRP port. Started by a one-cycle
// start strobe; reports completion or a DRDY timeout for the read or write
// half. The wait timeout counter lives in the parent; this block asks for it
// to be cleared in each request cycle so it starts at 0 in every wait state.
module drp_rmw_port
    import pll_ctrl_pkg::*;
(
    input  logic              clkin_int,
    input  logic              reset_active,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] mask,
    input  logic              drdy_expired,
    input  logic [DATA_W-1:0] pll_do,
    input  logic              pll_drdy,
    output logic [ADDR_W-1:0] pll_daddr,
    output logic              pll_den,
    output logic              pll_dwe,
    output logic [DATA_W-1:0] pll_di,
    output logic              cnt_clr,
    output logic              done,
    output logic              rd_timeout,
    output logic              wr_timeout
);

    state_t            state_r;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] mask_r;
    logic [ADDR_W-1:0] daddr_r;
    logic [DATA_W-1:0] di_r;
    logic              den_r;
    logic              dwe_r;

    // DRP sequencing: strobes are registered so they are high exactly in the request states.
    always_ff @(posedge clkin_int or posedge reset_active) begin
        if (reset_active) begin
            state_r <= ST_IDLE;
            data_r  <= {DATA_W{1'b0}};
            mask_r  <= {DATA_W{1'b0}};
            daddr_r <= {ADDR_W{1'b0}};
            di_r    <= {DATA_W{1'b0}};
            den_r   <= 1'b0;
            dwe_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        daddr_r <= addr;
                        data_r  <= data;
                        mask_r  <= mask;
                        den_r   <= 1'b1;
                        dwe_r   <= 1'b0;
                        state_r <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    den_r   <= 1'b0;
                    state_r <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    // DRDY takes priority over a timeout landing in the same cycle.
                    if (pll_drdy) begin
                        di_r    <= merge_bits(pll_do, data_r, mask_r);
                        den_r   <= 1'b1;
                        dwe_r   <= 1'b1;
                        state_r <= ST_WR_REQ;
                    end else if (drdy_expired) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    den_r   <= 1'b0;
                    dwe_r   <= 1'b0;
                    state_r <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (pll_drdy || drdy_expired) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    den_r   <= 1'b0;
                    dwe_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake back to the parent sequencer.
    always_comb begin
        cnt_clr    = (state_r == ST_RD_REQ) || (state_r == ST_WR_REQ);
        done       = (state_r == ST_WR_WAIT) && pll_drdy;
        rd_timeout = (state_r == ST_RD_WAIT) && !pll_drdy && drdy_expired;
        wr_timeout = (state_r == ST_WR_WAIT) && !pll_drdy && drdy_expired;
    end

    assign pll_daddr = daddr_r;
    assign pll_den   = den_r;
    assign pll_dwe   = dwe_r;
    assign pll_di    = di_r;

endmodule

// File: rtl/pll_drp_reconfig_ctrl.sv
// PLL reconfiguration sequencer: accepts masked DRP writes from the host,
// runs each as a read-modify-write, and after the last one pulses PLL RST
// and waits for LOCKED. Errors abort to IDLE without resetting the PLL.
module pll_drp_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 16,
    parameter int LOCK_TIMEOUT = 1023,
    parameter int RST_HOLD     = 4
) (
    input  logic              clkin_int,
    input  logic              reset_active,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic              cfg_last,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              pll_rst,
    output logic [ADDR_W-1:0] pll_daddr,
    output logic              pll_den,
    output logic              pll_dwe,
    output logic [DATA_W-1:0] pll_di,
    input  logic [DATA_W-1:0] pll_do,
    input  logic              pll_drdy,
    input  logic              pll_locked
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] DRDY_LAST  = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_HOLD - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_clr_s;
    logic             last_r;
    logic             last_nxt_s;
    logic             start_s;
    logic             cfg_ready_r;
    logic             busy_r;
    logic             done_r;
    logic             done_nxt_s;
    logic             error_r;
    logic             error_nxt_s;
    logic [1:0]       err_code_r;
    logic [1:0]       err_code_nxt_s;
    logic             pll_rst_r;
    logic             rmw_cnt_clr_s;
    logic             rmw_done_s;
    logic             rd_to_s;
    logic             wr_to_s;
    logic             drdy_exp_s;

    assign drdy_exp_s = (cnt_r == DRDY_LAST);

    drp_rmw_port u_rmw (
        .clkin_int    (clkin_int),
        .reset_active (reset_active),
        .start        (start_s),
        .addr         (cfg_addr),
        .data         (cfg_data),
        .mask         (cfg_mask),
        .drdy_expired (drdy_exp_s),
        .pll_do       (pll_do),
        .pll_drdy     (pll_drdy),
        .pll_daddr    (pll_daddr),
        .pll_den      (pll_den),
        .pll_dwe      (pll_dwe),
        .pll_di       (pll_di),
        .cnt_clr      (rmw_cnt_clr_s),
        .done         (rmw_done_s),
        .rd_timeout   (rd_to_s),
        .wr_timeout   (wr_to_s)
    );

    // Next-state and status decisions for the IDLE, DRP, RST and lock phases.
    always_comb begin
        state_nxt_s    = state_r;
        last_nxt_s     = last_r;
        done_nxt_s     = 1'b0;
        error_nxt_s    = error_r;
        err_code_nxt_s = err_code_r;
        start_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_valid) begin
                    start_s        = 1'b1;
                    last_nxt_s     = cfg_last;
                    error_nxt_s    = 1'b0;
                    err_code_nxt_s = ERR_NONE;
                    state_nxt_s    = ST_DRP_BUSY;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_DRP_BUSY: begin
                if (rmw_done_s) begin
                    state_nxt_s    = last_r ? ST_RST_ASSERT : ST_IDLE;
                end else if (rd_to_s) begin
                    error_nxt_s    = 1'b1;
                    err_code_nxt_s = ERR_RD_TO;
                    state_nxt_s    = ST_IDLE;
                end else if (wr_to_s) begin
                    error_nxt_s    = 1'b1;
                    err_code_nxt_s = ERR_WR_TO;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    state_nxt_s    = ST_DRP_BUSY;
                end
            end
            ST_RST_ASSERT: begin
                if (cnt_r == RST_LAST) begin
                    state_nxt_s = ST_LOCK_WAIT;
                end else begin
                    state_nxt_s = ST_RST_ASSERT;
                end
            end
            ST_LOCK_WAIT: begin
                if (pll_locked) begin
                    done_nxt_s     = 1'b1;
                    state_nxt_s    = ST_IDLE;
                end else if (cnt_r == LOCK_LAST) begin
                    error_nxt_s    = 1'b1;
                    err_code_nxt_s = ERR_LOCK_TO;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    state_nxt_s    = ST_LOCK_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // The counter restarts on every state entry, including the sub-module's wait states.
    assign cnt_clr_s = rmw_cnt_clr_s || (state_nxt_s != state_r);

    // Shared timeout counter, saturating at its limit.
    always_ff @(posedge clkin_int or posedge reset_active) begin
        if (reset_active) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r != CNT_LIMIT) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // State and registered status outputs.
    always_ff @(posedge clkin_int or posedge reset_active) begin
        if (reset_active) begin
            state_r     <= ST_IDLE;
            last_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            err_code_r  <= ERR_NONE;
            pll_rst_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            last_r      <= last_nxt_s;
            cfg_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= done_nxt_s;
            error_r     <= error_nxt_s;
            err_code_r  <= err_code_nxt_s;
            pll_rst_r   <= (state_nxt_s == ST_RST_ASSERT);
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;
    assign err_code  = err_code_r;
    assign pll_rst   = pll_rst_r;

endmodule

// File: tb/tb_pll_drp_reconfig_ctrl.sv
// Bench for pll_drp_reconfig_ctrl: a behavioural PLL (DRP register file with
// programmable DRDY delays, LOCKED after a programmable delay) plus a
// reference model of the expected register contents, latencies and status.
module tb_pll_drp_reconfig_ctrl;

    localparam int DRDY_TO = 16;
    localparam int LOCK_TO = 1023;
    localparam int RST_H   = 4;

    logic        clkin_int;
    logic        reset_active;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [15:0] cfg_mask;
    logic        cfg_last;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic        pll_rst;
    logic [6:0]  pll_daddr;
    logic        pll_den;
    logic        pll_dwe;
    logic [15:0] pll_di;
    logic [15:0] pll_do;
    logic        pll_drdy;
    logic        pll_locked;

    pll_drp_reconfig_ctrl dut (
        .clkin_int    (clkin_int),
        .reset_active (reset_active),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_mask     (cfg_mask),
        .cfg_last     (cfg_last),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .pll_rst      (pll_rst),
        .pll_daddr    (pll_daddr),
        .pll_den      (pll_den),
        .pll_dwe      (pll_dwe),
        .pll_di       (pll_di),
        .pll_do       (pll_do),
        .pll_drdy     (pll_drdy),
        .pll_locked   (pll_locked)
    );

    initial begin
        clkin_int = 1'b0;
        forever #5 clkin_int = ~clkin_int;
    end

    // PLL model state and activity counters
    logic [15:0] mem [128];
    logic [15:0] exp_mem [128];
    int rd_delay, wr_delay, lock_delay;
    int pend, lcnt;
    logic armed, p_we;
    logic [6:0] p_addr;
    logic [15:0] p_di, last_di;
    int den_cnt, wr_cnt, rst_cyc, done_cnt, viol;

    int errors, checks;

    // Behavioural PLL: evaluated at falling edges, away from the active edge.
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        mem[1] = 16'h5678;
        pll_drdy = 1'b0; pll_do = 16'h0000; pll_locked = 1'b0;
        pend = 0; lcnt = 0; armed = 1'b0; p_we = 1'b0; p_addr = 7'd0; p_di = 16'h0000;
        last_di = 16'h0000;
        den_cnt = 0; wr_cnt = 0; rst_cyc = 0; done_cnt = 0; viol = 0;
        forever begin
            @(negedge clkin_int);
            pll_drdy = 1'b0;
            if (pll_rst && (pll_den || pend != 0)) viol++;
            if (pll_rst) rst_cyc++;
            if (done) done_cnt++;
            if (reset_active) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        pll_drdy = 1'b1;
                        if (p_we) mem[p_addr] = p_di;
                        else pll_do = mem[p_addr];
                    end
                end
                if (pll_den) begin
                    den_cnt++;
                    p_addr = pll_daddr;
                    p_we   = pll_dwe;
                    p_di   = pll_di;
                    pend   = pll_dwe ? wr_delay : rd_delay;
                    if (pll_dwe) begin
                        wr_cnt++;
                        last_di = pll_di;
                    end
                end
            end
            if (pll_rst) begin
                pll_locked = 1'b0; lcnt = 0; armed = 1'b1;
            end else if (armed) begin
                lcnt++;
                if (lock_delay != 0 && lcnt == lock_delay) begin
                    pll_locked = 1'b1;
                    armed = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One host write with the given PLL timing; all expectations derived here.
    task automatic run_cfg(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m,
                           input logic l, input int rd, input int wr, input int lk, input string tag);
        int exp_cyc, cyc, d_den, d_wr, d_rst, d_done;
        logic [1:0] exp_code;
        logic wrote, locked_ok;
        if (rd == 0 || rd > DRDY_TO) begin
            exp_code = 2'd1; exp_cyc = 1 + DRDY_TO;
        end else if (wr == 0 || wr > DRDY_TO) begin
            exp_code = 2'd2; exp_cyc = 2 + rd + DRDY_TO;
        end else if (!l) begin
            exp_code = 2'd0; exp_cyc = 2 + rd + wr;
        end else if (lk == 0 || lk > LOCK_TO) begin
            exp_code = 2'd3; exp_cyc = 2 + rd + wr + RST_H + LOCK_TO;
        end else begin
            exp_code = 2'd0; exp_cyc = 2 + rd + wr + RST_H + lk;
        end
        wrote     = (exp_code == 2'd0) || (exp_code == 2'd3);
        locked_ok = l && (exp_code == 2'd0);
        if (wrote) exp_mem[a] = (exp_mem[a] & ~m) | (d & m);
        rd_delay = rd; wr_delay = wr; lock_delay = lk;
        d_den = den_cnt; d_wr = wr_cnt; d_rst = rst_cyc; d_done = done_cnt;
        check({tag, "/ready_idle"}, 32'(cfg_ready), 32'd1);
        cfg_addr = a; cfg_data = d; cfg_mask = m; cfg_last = l; cfg_valid = 1'b1;
        @(posedge clkin_int);
        @(negedge clkin_int); #1;
        cfg_valid = 1'b0;
        check({tag, "/ready_busy"}, 32'(cfg_ready), 32'd0);
        cyc = 0;
        while (busy === 1'b1 && cyc < 3000) begin
            cyc++;
            @(negedge clkin_int); #1;
        end
        check({tag, "/latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "/error"}, 32'(error), 32'(exp_code != 2'd0));
        check({tag, "/err_code"}, 32'(err_code), 32'(exp_code));
        check({tag, "/done"}, 32'(done), 32'(locked_ok));
        check({tag, "/den_count"}, 32'(den_cnt - d_den), wrote || exp_code == 2'd2 ? 32'd2 : 32'd1);
        check({tag, "/wr_strobes"}, 32'(wr_cnt - d_wr), exp_code == 2'd1 ? 32'd0 : 32'd1);
        check({tag, "/rst_cycles"}, 32'(rst_cyc - d_rst), (l && wrote) ? 32'(RST_H) : 32'd0);
        check({tag, "/mem"}, 32'(mem[a]), 32'(exp_mem[a]));
        @(negedge clkin_int); #1;
        check({tag, "/done_pulses"}, 32'(done_cnt - d_done), 32'(locked_ok));
        check({tag, "/done_low"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [6:0]  ra;
        logic [15:0] rdat, rmsk;
        errors = 0; checks = 0;
        cfg_valid = 1'b0; cfg_addr = 7'd0; cfg_data = 16'h0000; cfg_mask = 16'h0000; cfg_last = 1'b0;
        rd_delay = 1; wr_delay = 1; lock_delay = 50;
        reset_active = 1'b0;
        #1;
        for (int i = 0; i < 128; i++) exp_mem[i] = mem[i];
        reset_active = 1'b1;
        #2;
        check("reset/ready", 32'(cfg_ready), 32'd1);
        check("reset/outs", 32'({busy, done, error, err_code, pll_rst, pll_den, pll_dwe}), 32'd0);
        check("reset/drp", 32'({pll_daddr, pll_di}), 32'd0);
        repeat (3) @(negedge clkin_int);
        #1 reset_active = 1'b0;
        @(negedge clkin_int); #1;

        // Single masked non-last write
        run_cfg(7'h01, 16'h00AB, 16'h00FF, 1'b0, 1, 1, 50, "single");
        check("single/di", 32'(last_di), 32'h56AB);

        // Three-write sequence with lock after 50 cycles
        run_cfg(7'h00, 16'hA5A5, 16'hF0F0, 1'b0, 1, 1, 50, "seq0");
        run_cfg(7'h02, 16'h1234, 16'h0FF0, 1'b0, 1, 1, 50, "seq2");
        run_cfg(7'h03, 16'hBEEF, 16'hFFFF, 1'b1, 1, 1, 50, "seq3");

        // Timeouts and boundaries
        run_cfg(7'h10, 16'h1111, 16'hFFFF, 1'b0, 0, 1, 50, "rd_to");
        run_cfg(7'h11, 16'h2222, 16'h00FF, 1'b0, 2, 0, 50, "wr_to");
        run_cfg(7'h12, 16'h3333, 16'hFF00, 1'b0, 16, 16, 50, "drdy_edge");
        run_cfg(7'h13, 16'h4444, 16'hFFFF, 1'b0, 17, 1, 50, "drdy_late");
        run_cfg(7'h14, 16'h5555, 16'h0F0F, 1'b1, 1, 1, 0, "lock_to");

        // Asynchronous reset while waiting for the write DRDY
        rd_delay = 1; wr_delay = 0;
        cfg_addr = 7'h20; cfg_data = 16'hCAFE; cfg_mask = 16'hFFFF; cfg_last = 1'b1; cfg_valid = 1'b1;
        @(posedge clkin_int);
        @(negedge clkin_int); #1;
        cfg_valid = 1'b0;
        repeat (3) begin
            @(negedge clkin_int); #1;
        end
        check("rst_mid/in_wr_wait", 32'({busy, pll_den}), 32'h2);
        reset_active = 1'b1;
        #1;
        check("rst_mid/ready", 32'(cfg_ready), 32'd1);
        check("rst_mid/outs", 32'({busy, done, error, err_code, pll_rst, pll_den, pll_dwe}), 32'd0);
        check("rst_mid/drp", 32'({pll_daddr, pll_di}), 32'd0);
        @(negedge clkin_int); #1;
        reset_active = 1'b0;
        repeat (3) begin
            @(negedge clkin_int); #1;
        end
        check("rst_mid/idle_after", 32'({busy, pll_rst}), 32'd0);
        check("rst_mid/mem", 32'(mem[7'h20]), 32'(exp_mem[7'h20]));
        run_cfg(7'h20, 16'hCAFE, 16'h00FF, 1'b0, 1, 1, 50, "after_rst");

        // Randomized writes
        for (int n = 0; n < 16; n++) begin
            ra   = 7'($urandom_range(0, 127));
            rdat = 16'($urandom);
            rmsk = 16'($urandom);
            run_cfg(ra, rdat, rmsk, ($urandom_range(0, 3) == 0),
                    $urandom_range(1, 16), $urandom_range(1, 16), $urandom_range(1, 60),
                    $sformatf("rand%0d", n));
        end

        check("rst_during_drp", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
